// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, mem_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, mem_err, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the shared multicycle MIPS datapath.
// Mux selects come from the state register; strobes that complete a memory
// access are qualified by mem_ready, and the branch PC load by the ALU zero flag.
// A wait counter aborts memory states that never see mem_ready.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             mem_state_s;
  logic             timeout_s;
  logic             pc_write_s;
  logic             branch_s;

  // Dispatch target for the opcode held in IR during DECODE.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW,
      OP_SW:    nxt = S_MEMADR;
      OP_RTYPE: nxt = S_EXEC;
      OP_BEQ:   nxt = S_BRANCH;
      OP_ADDI:  nxt = S_ADDIEX;
      OP_J:     nxt = S_JUMP;
      default:  nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // True for opcodes this controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Memory-state detection and stuck-access timeout; a ready in the limit cycle wins.
  always_comb begin
    mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    timeout_s   = mem_state_s && !bus.mem_ready && (wait_cnt_r == TIMEOUT_CNT);
  end

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: next_state_s = decode_next(bus.opcode);
      S_MEMADR: begin
        if (bus.opcode == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (bus.mem_ready) begin
          next_state_s = S_MEMWB;
        end else if (timeout_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (bus.mem_ready || timeout_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMWB:  next_state_s = S_FETCH;
      S_EXEC:   next_state_s = S_ALUWB;
      S_ALUWB:  next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_ADDIEX: next_state_s = S_ADDIWB;
      S_ADDIWB: next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // State register and memory wait counter; counter restarts whenever a wait ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (mem_state_s && !bus.mem_ready && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Per-state datapath control decode; everything is forced low while in reset.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 2'b00;
    bus.illegal_op = 1'b0;
    bus.mem_err    = 1'b0;
    pc_write_s     = 1'b0;
    branch_s       = 1'b0;
    if (reset) begin
      pc_write_s = 1'b0;
    end else begin
      bus.mem_err = timeout_s;
      case (state_r)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          pc_write_s    = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.illegal_op = !op_supported(bus.opcode);
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.iord      = 1'b1;
          bus.mem_write = bus.mem_ready;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b01;
          bus.pc_src    = 2'b01;
          branch_s      = 1'b1;
        end
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_ADDIWB: bus.reg_write = 1'b1;
        S_JUMP: begin
          bus.pc_src = 2'b10;
          pc_write_s = 1'b1;
        end
        default: pc_write_s = 1'b0;
      endcase
    end
    bus.pc_en = pc_write_s | (branch_s & bus.zero);
  end

  assign bus.state = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a driver applies directed then
// random inputs each cycle and queues the expected control word computed
// from an instruction-path model; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  localparam int TMO = 15;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    logic       mem_err;
  } ctl_t;

  ctl_t exp_q[$];
  int   plan[$];      // remaining steps of the current instruction; plan[0] is now
  int   waitc = 0;    // cycles already spent waiting in the current memory step
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  function automatic ctl_t sample();
    ctl_t a;
    a.state      = bus.state;
    a.mem_req    = bus.mem_req;
    a.iord       = bus.iord;
    a.mem_write  = bus.mem_write;
    a.ir_write   = bus.ir_write;
    a.reg_dst    = bus.reg_dst;
    a.mem_to_reg = bus.mem_to_reg;
    a.reg_write  = bus.reg_write;
    a.alu_src_a  = bus.alu_src_a;
    a.alu_src_b  = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    a.pc_src     = bus.pc_src;
    a.pc_en      = bus.pc_en;
    a.illegal_op = bus.illegal_op;
    a.mem_err    = bus.mem_err;
    return a;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Expected controls for the step the model is in, given this cycle's inputs.
  function automatic ctl_t expected(input int cur, input int wc, input bit rst,
                                    input bit rdy, input bit z, input logic [5:0] op);
    ctl_t e;
    bit   stuck;
    e       = '0;
    e.state = 4'(cur);
    stuck   = !rdy && (wc == TMO);
    if (!rst) begin
      case (cur)
        0: begin
          e.mem_req = 1'b1; e.alu_src_b = 2'b01;
          e.ir_write = rdy; e.pc_en = rdy; e.mem_err = stuck;
        end
        1: begin e.alu_src_b = 2'b11; e.illegal_op = !legal(op); end
        2: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        3: begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_err = stuck; end
        4: begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
        5: begin
          e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = rdy; e.mem_err = stuck;
        end
        6: begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
        7: begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
        8: begin
          e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z;
        end
        9: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
        10: e.reg_write = 1'b1;
        11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  // Advance the instruction-path model by one clock.
  task automatic model_step(input bit rst, input bit rdy, input logic [5:0] op);
    int cur;
    cur = plan[0];
    if (rst) begin
      plan = {0};
      waitc = 0;
    end else if (cur == 0 || cur == 3 || cur == 5) begin
      if (rdy) begin
        waitc = 0;
        if (cur == 0) plan = {1};
        else void'(plan.pop_front());
      end else if (waitc == TMO) begin
        waitc = 0;
        plan = {0};
      end else begin
        waitc++;
      end
    end else if (cur == 1) begin
      case (op)
        OP_LW:    plan = {2, 3, 4};
        OP_SW:    plan = {2, 5};
        OP_RTYPE: plan = {6, 7};
        OP_BEQ:   plan = {8};
        OP_ADDI:  plan = {9, 10};
        OP_J:     plan = {11};
        default:  plan = {0};
      endcase
    end else begin
      void'(plan.pop_front());
    end
    if (plan.size() == 0) plan.push_back(0);
  endtask

  // One clock of stimulus: apply inputs, queue the expectation, step the model.
  task automatic drive(input bit rst, input bit rdy, input bit z, input logic [5:0] op);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.opcode    = op;
    exp_q.push_back(expected(plan[0], waitc, rst, rdy, z, op));
    model_step(rst, rdy, op);
    cyc++;
  endtask

  task automatic drive_n(input int n, input bit rst, input bit rdy, input bit z,
                         input logic [5:0] op);
    for (int i = 0; i < n; i++) drive(rst, rdy, z, op);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
  initial begin
    ctl_t e;
    ctl_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        checks++;
        if (a === e) begin
          passed++;
        end else begin
          $display("FAIL ctl_word t=%0t: got %h required %h (state got %0d required %0d)",
                   $time, a, e, a.state, e.state);
        end
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] ops[6];
    int         stall;
    bit         rdy;
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    plan = {0};
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.opcode    = OP_LW;

    // reset held three cycles, then lw with no wait states: 0,1,2,3,4
    drive_n(3, 1'b1, 1'b1, 1'b0, OP_LW);
    drive_n(5, 1'b0, 1'b1, 1'b0, OP_LW);
    // beq taken then not taken
    drive_n(3, 1'b0, 1'b1, 1'b1, OP_BEQ);
    drive_n(3, 1'b0, 1'b1, 1'b0, OP_BEQ);
    // sw with three wait cycles in MEMWR
    drive_n(3, 1'b0, 1'b1, 1'b0, OP_SW);
    drive_n(3, 1'b0, 1'b0, 1'b0, OP_SW);
    drive_n(1, 1'b0, 1'b1, 1'b0, OP_SW);
    // FETCH stuck for 16 cycles -> timeout, then ready exactly in cycle 16
    drive_n(16, 1'b0, 1'b0, 1'b0, OP_RTYPE);
    drive_n(15, 1'b0, 1'b0, 1'b0, OP_RTYPE);
    drive_n(4, 1'b0, 1'b1, 1'b0, OP_RTYPE);
    // illegal opcode, then addi and j
    drive_n(2, 1'b0, 1'b1, 1'b0, OP_BAD);
    drive_n(4, 1'b0, 1'b1, 1'b0, OP_ADDI);
    drive_n(3, 1'b0, 1'b1, 1'b0, OP_J);
    // lw stalled in MEMRD, aborted by reset
    drive_n(3, 1'b0, 1'b1, 1'b0, OP_LW);
    drive_n(2, 1'b0, 1'b0, 1'b0, OP_LW);
    drive_n(1, 1'b1, 1'b1, 1'b0, OP_LW);
    drive_n(2, 1'b0, 1'b1, 1'b0, OP_LW);

    // randomized traffic with occasional long stalls and resets
    stall = 0;
    op = OP_LW;
    for (int i = 0; i < 2000; i++) begin
      if (plan[0] == 0) begin
        if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
        else op = ops[$urandom_range(0, 5)];
      end
      if (stall > 0) begin
        stall--;
        rdy = 1'b0;
      end else if ($urandom_range(0, 63) == 0) begin
        stall = $urandom_range(10, 20);
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      drive(($urandom_range(0, 199) == 0), rdy, 1'($urandom_range(0, 1)), op);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
